logit_readout: RTL and testbench
================================

LOGIT_READOUT -- requirements
Module: logit_readout

Interface
REQ-001 Parameter DATA_WIDTH, default 32, shall set the logit and cycle-count word width (signed Q16.16 logits).
REQ-002 Parameter ADDR_WIDTH, default 16, shall set the output-RAM address width.
REQ-003 Parameter N_LOGITS, default 10, shall set the number of logits read.
REQ-004 Parameter LOGIT_BASE_ADDR, default 1, shall set the address of logit 0; the cycle-count word is at LOGIT_BASE_ADDR+N_LOGITS (default 11).
REQ-005 Parameter READ_LATENCY, default 1, shall set the cycles from address presentation to valid ram_data_i (range 1..4).
REQ-006 clock_i  in  1  single clock; all logic shall be on its rising edge.
REQ-007 reset_i  in  1  synchronous, active-low reset.
REQ-008 start_i  in  1  request one readout pass; sampled only in IDLE or DONE.
REQ-009 ram_data_i  in  DATA_WIDTH  output-RAM read data.
REQ-010 ram_rdaddress_o  out  ADDR_WIDTH  output-RAM read address.
REQ-011 busy_o  out  1  high while a pass is in progress.
REQ-012 done_o  out  1  single-cycle pulse when a pass completes.
REQ-013 valid_o  out  1  high from completion until the next accepted start or reset.
REQ-014 class_o  out  $clog2(N_LOGITS)  index of the maximum logit.
REQ-015 max_logit_o  out  DATA_WIDTH  value of the maximum logit, signed.
REQ-016 total_cycles_o  out  DATA_WIDTH  cycle-count word read after the logits.

Function
REQ-017 FSM states shall be IDLE, READ, DRAIN and DONE; the reset state shall be IDLE.
REQ-018 IDLE/DONE to READ on start_i=1: clear valid_o, load ram_rdaddress_o=LOGIT_BASE_ADDR, arm the comparator.
REQ-019 In READ, ram_rdaddress_o shall increment by 1 per cycle through LOGIT_BASE_ADDR+N_LOGITS (N_LOGITS+1 addresses, back to back), then the FSM moves to DRAIN.
REQ-020 A READ_LATENCY-deep valid/index shift register shall tag each returned word; words 0..N_LOGITS-1 are logits and word N_LOGITS is the cycle count.
REQ-021 Logit 0 shall unconditionally load max_logit/class=0; each later logit replaces the maximum only on signed strict greater-than, so ties keep the lower index.
REQ-022 DRAIN shall move to DONE on capture of the cycle-count word into total_cycles_o; on that transition done_o shall pulse for exactly 1 cycle and valid_o shall rise.
REQ-023 done_o shall assert exactly N_LOGITS+2+READ_LATENCY cycles after the edge that accepts start_i (13 with defaults).
REQ-024 start_i in READ or DRAIN shall be ignored, with no restart and no queuing.
REQ-025 start_i held high in DONE shall begin a new pass on the cycle after done_o.
REQ-026 busy_o shall be high exactly in READ and DRAIN.
REQ-027 class_o, max_logit_o and total_cycles_o shall hold their last values until the next accepted start; only the internal maximum shall be rearmed.
REQ-028 Outside READ, ram_rdaddress_o shall hold its last value.

Reset
REQ-029 With reset_i=0 at a clock edge, the next state shall be IDLE, busy_o=done_o=valid_o=0, class_o=0, max_logit_o=0, total_cycles_o=0, ram_rdaddress_o=0, and the valid pipeline shall be empty.
REQ-030 Reset in mid-pass shall abandon the pass with no done_o pulse; late RAM data arriving after reset shall be discarded.

Structure
REQ-031 A shared package shall hold the state enum and the default parameter constants (N_LOGITS, LOGIT_BASE_ADDR, READ_LATENCY).
REQ-032 The signed compare-and-hold logic shall be one sub-module, signed_argmax, with inputs first/valid/index/value and outputs max/index.

Verification
REQ-033 RAM[1..10]={0x654,0x2BD9,0xFFFFFAA6,0xFFFFEFBA,0xFFFFEDCB,0xFFFFF75A,0xFFFFF8F2,0x8C6,0xF7,0x1DA} and RAM[11]=0x00012345, start -> done_o at cycle 13, class_o=1, max_logit_o=0x2BD9, total_cycles_o=0x12345.
REQ-034 All logits negative, logit k = -(k+1) -> class_o=0, max_logit_o=0xFFFFFFFF (signed compare, not unsigned).
REQ-035 Logits 3 and 7 both 0x00010000, all others 0 -> class_o=3 (lower index wins the tie).
REQ-036 start_i pulsed again at cycles 3 and 8 of a pass -> a single done_o at cycle 13 and addresses 1..11 each issued exactly once.
REQ-037 reset_i=0 at cycle 5 of a pass -> all outputs 0 and no done_o; a following start completes normally with correct results.
REQ-038 READ_LATENCY=3 with the REQ-033 data -> identical results, done_o at cycle 15.

Source files
------------

// File: rtl/logit_readout_pkg.sv
// ---------------------------------------------------------------------------
// logit_readout_pkg
// Shared definitions for the logit readout block: the readout FSM state
// encoding, the default parameter values used by the top, the interface and
// the argmax sub-module, and a small width helper.
// ---------------------------------------------------------------------------
package logit_readout_pkg;

  // Default configuration: ten signed Q16.16 logits at addresses 1..10, with
  // the accelerator's cycle-count word directly after them at address 11.
  localparam int unsigned DataWidthDef     = 32;
  localparam int unsigned AddrWidthDef     = 16;
  localparam int unsigned NLogitsDef       = 10;
  localparam int unsigned LogitBaseAddrDef = 1;
  localparam int unsigned ReadLatencyDef   = 1;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } state_e;

  // Width of a word index covering logits 0..n-1 plus the trailing count word.
  function automatic int unsigned word_idx_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/logit_readout_if.sv
// ---------------------------------------------------------------------------
// logit_readout_if
// Bundles the control, output-RAM read port and result signals of
// logit_readout. Signal names carry direction suffixes as seen from the
// readout block.
//   start_i          request one readout pass
//   ram_data_i       output-RAM read data
//   ram_rdaddress_o  output-RAM read address
//   busy_o           pass in progress
//   done_o           one-cycle completion pulse
//   valid_o          results valid since last completion
//   class_o          index of the maximum logit
//   max_logit_o      maximum logit value (signed)
//   total_cycles_o   cycle-count word read after the logits
// Modports: master = the readout block, slave = its environment.
// ---------------------------------------------------------------------------
interface logit_readout_if
  import logit_readout_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDef,
  parameter int unsigned ADDR_WIDTH = AddrWidthDef,
  parameter int unsigned N_LOGITS   = NLogitsDef
);

  localparam int unsigned ClassW = $clog2(N_LOGITS);

  logic                  start_i;
  logic [DATA_WIDTH-1:0] ram_data_i;
  logic [ADDR_WIDTH-1:0] ram_rdaddress_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  valid_o;
  logic [ClassW-1:0]     class_o;
  logic [DATA_WIDTH-1:0] max_logit_o;
  logic [DATA_WIDTH-1:0] total_cycles_o;

  modport master (
    input  start_i,
    input  ram_data_i,
    output ram_rdaddress_o,
    output busy_o,
    output done_o,
    output valid_o,
    output class_o,
    output max_logit_o,
    output total_cycles_o
  );

  modport slave (
    output start_i,
    output ram_data_i,
    input  ram_rdaddress_o,
    input  busy_o,
    input  done_o,
    input  valid_o,
    input  class_o,
    input  max_logit_o,
    input  total_cycles_o
  );

endinterface

// File: rtl/signed_argmax.sv
// ---------------------------------------------------------------------------
// signed_argmax
// Running signed maximum with index. A word flagged first_i loads
// unconditionally (this is how a new pass rearms it); later words replace
// the held maximum only when strictly greater, so ties keep the lower index.
//   clock_i   clock, rising edge
//   reset_i   synchronous active-low reset
//   first_i   current word is logit 0 of a pass
//   valid_i   current word is a logit to be compared
//   index_i   logit index of the current word
//   value_i   logit value (two's complement)
//   max_o     held maximum value
//   index_o   index of the held maximum
// ---------------------------------------------------------------------------
module signed_argmax
  import logit_readout_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDef,
  parameter int unsigned IDX_WIDTH  = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  first_i,
  input  logic                  valid_i,
  input  logic [IDX_WIDTH-1:0]  index_i,
  input  logic [DATA_WIDTH-1:0] value_i,
  output logic [DATA_WIDTH-1:0] max_o,
  output logic [IDX_WIDTH-1:0]  index_o
);

  logic [DATA_WIDTH-1:0] max_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic                  take;

  assign take = valid_i && (first_i || ($signed(value_i) > $signed(max_q)));

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      max_q <= '0;
      idx_q <= '0;
    end else if (take) begin
      max_q <= value_i;
      idx_q <= index_i;
    end
  end

  assign max_o   = max_q;
  assign index_o = idx_q;

endmodule

// File: rtl/logit_readout.sv
// ---------------------------------------------------------------------------
// logit_readout
// Reads N_LOGITS signed logits plus a trailing cycle-count word from an
// output RAM, finds the index and value of the largest logit and presents
// the results with a done pulse.
//   clock_i   clock, rising edge
//   reset_i   synchronous active-low reset
//   bus       logit_readout_if master modport (start, RAM read port,
//             busy/done/valid and the three result words)
// Flow: IDLE/DONE --start--> READ issues N_LOGITS+1 back-to-back addresses,
// DRAIN waits for the count word to come back, DONE holds the results.
// READ_LATENCY must lie in 1..4.
// ---------------------------------------------------------------------------
module logit_readout
  import logit_readout_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DataWidthDef,
  parameter int unsigned ADDR_WIDTH      = AddrWidthDef,
  parameter int unsigned N_LOGITS        = NLogitsDef,
  parameter int unsigned LOGIT_BASE_ADDR = LogitBaseAddrDef,
  parameter int unsigned READ_LATENCY    = ReadLatencyDef
) (
  input logic            clock_i,
  input logic            reset_i,
  logit_readout_if.master bus
);

  localparam int unsigned    IdxW     = word_idx_width(N_LOGITS);
  localparam int unsigned    ClassW   = $clog2(N_LOGITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_LOGITS);
  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(LOGIT_BASE_ADDR);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [IdxW-1:0]         rd_idx_q;     // index of the word whose address is on the bus

  // Tag pipeline: follows each issued address until its data is on ram_data_i.
  logic [READ_LATENCY-1:0] tag_vld_q;
  logic [IdxW-1:0]         tag_idx_q [READ_LATENCY];

  // Returned word re-registered before use so compare and capture start from flops.
  logic                    word_vld_q;
  logic [IdxW-1:0]         word_idx_q;
  logic [DATA_WIDTH-1:0]   word_data_q;

  logic                    busy_q;
  logic                    done_q;
  logic                    valid_q;
  logic [ClassW-1:0]       class_q;
  logic [DATA_WIDTH-1:0]   max_q;
  logic [DATA_WIDTH-1:0]   total_q;

  logic                    am_first;
  logic                    am_valid;
  logic [DATA_WIDTH-1:0]   am_max;
  logic [ClassW-1:0]       am_idx;
  logic                    count_word;

  assign am_first   = (word_idx_q == '0);
  assign am_valid   = word_vld_q && (word_idx_q != LastIdx);
  assign count_word = word_vld_q && (word_idx_q == LastIdx);

  signed_argmax #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (ClassW)
  ) u_argmax (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .first_i (am_first),
    .valid_i (am_valid),
    .index_i (word_idx_q[ClassW-1:0]),
    .value_i (word_data_q),
    .max_o   (am_max),
    .index_o (am_idx)
  );

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      rd_idx_q    <= '0;
      tag_vld_q   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_idx_q[i] <= '0;
      end
      word_vld_q  <= 1'b0;
      word_idx_q  <= '0;
      word_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      class_q     <= '0;
      max_q       <= '0;
      total_q     <= '0;
    end else begin
      done_q <= 1'b0;

      tag_vld_q[0] <= (state_q == StRead);
      tag_idx_q[0] <= rd_idx_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end

      word_vld_q  <= tag_vld_q[READ_LATENCY-1];
      word_idx_q  <= tag_idx_q[READ_LATENCY-1];
      word_data_q <= bus.ram_data_i;

      case (state_q)
        StIdle, StDone: begin
          if (bus.start_i) begin
            state_q  <= StRead;
            addr_q   <= BaseAddr;
            rd_idx_q <= '0;
            busy_q   <= 1'b1;
            valid_q  <= 1'b0;
          end
        end
        StRead: begin
          if (rd_idx_q == LastIdx) begin
            state_q <= StDrain;
          end else begin
            addr_q   <= addr_q + 1'b1;
            rd_idx_q <= rd_idx_q + 1'b1;
          end
        end
        StDrain: begin
          // The last logit was folded into the argmax on the previous edge.
          if (count_word) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            total_q <= word_data_q;
            class_q <= am_idx;
            max_q   <= am_max;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ram_rdaddress_o = addr_q;
  assign bus.busy_o          = busy_q;
  assign bus.done_o          = done_q;
  assign bus.valid_o         = valid_q;
  assign bus.class_o         = class_q;
  assign bus.max_logit_o     = max_q;
  assign bus.total_cycles_o  = total_q;

endmodule

// File: tb/tb_logit_readout.sv
// ---------------------------------------------------------------------------
// tb_logit_readout
// Runs two readout instances side by side (read latency 1 and 3) against a
// shared RAM image and checks them against an argmax computed directly from
// the RAM contents.
// ---------------------------------------------------------------------------
module tb_logit_readout;

  localparam int N    = 10;
  localparam int BASE = 1;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        valid;
    logic [3:0]  cls;
    logic [31:0] mx;
    logic [31:0] tot;
    logic [15:0] addr;
  } samp_t;

  logic clk;
  logic reset_n;
  logic start;

  bit   [31:0] mem [64];
  logic [31:0] pipe1 [1];
  logic [31:0] pipe3 [3];

  int tests;
  int failures;

  logit_readout_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .N_LOGITS(N)) bus1 ();
  logit_readout_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .N_LOGITS(N)) bus3 ();

  logit_readout #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .N_LOGITS(N), .LOGIT_BASE_ADDR(BASE), .READ_LATENCY(1)
  ) dut1 (
    .clock_i (clk),
    .reset_i (reset_n),
    .bus     (bus1.master)
  );

  logit_readout #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .N_LOGITS(N), .LOGIT_BASE_ADDR(BASE), .READ_LATENCY(3)
  ) dut3 (
    .clock_i (clk),
    .reset_i (reset_n),
    .bus     (bus3.master)
  );

  assign bus1.start_i    = start;
  assign bus3.start_i    = start;
  assign bus1.ram_data_i = pipe1[0];
  assign bus3.ram_data_i = pipe3[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: data appears READ_LATENCY cycles after the address.
  always @(posedge clk) begin
    pipe1[0] <= mem[bus1.ram_rdaddress_o[5:0]];
    pipe3[0] <= mem[bus3.ram_rdaddress_o[5:0]];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  function automatic samp_t grab(input int d);
    samp_t s;
    if (d == 0) s = '{bus1.busy_o, bus1.done_o, bus1.valid_o, bus1.class_o,
                      bus1.max_logit_o, bus1.total_cycles_o, bus1.ram_rdaddress_o};
    else        s = '{bus3.busy_o, bus3.done_o, bus3.valid_o, bus3.class_o,
                      bus3.max_logit_o, bus3.total_cycles_o, bus3.ram_rdaddress_o};
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input int d, input string tag);
    samp_t s;
    string t;
    s = grab(d);
    t = $sformatf("%s.L%0d", tag, (d == 0) ? 1 : 3);
    chk({t, ".busy"},  64'(s.busy),  64'd0);
    chk({t, ".done"},  64'(s.done),  64'd0);
    chk({t, ".valid"}, 64'(s.valid), 64'd0);
    chk({t, ".class"}, 64'(s.cls),   64'd0);
    chk({t, ".max"},   64'(s.mx),    64'd0);
    chk({t, ".total"}, 64'(s.tot),   64'd0);
    chk({t, ".addr"},  64'(s.addr),  64'd0);
  endtask

  // Reference: plain signed argmax over the logit words, first maximum wins.
  task automatic model(output int cls, output logic [31:0] mx);
    cls = 0;
    for (int k = 1; k < N; k++) begin
      if ($signed(mem[BASE + k]) > $signed(mem[BASE + cls])) cls = k;
    end
    mx = mem[BASE + cls];
  endtask

  // One pass: start accepted at edge 0, sampled 1 time unit after edges 0..21.
  // pa/pb: cycles during which start is re-pulsed; rst_at: cycle during which
  // reset is low (-1 for none); hold: keep start high throughout.
  task automatic run_pass(input string name, input int pa, input int pb,
                          input int rst_at, input bit hold);
    int          cls;
    logic [31:0] mx;
    logic [31:0] tot;
    int          dcnt [2];
    samp_t       s;
    string       t;
    model(cls, mx);
    tot     = mem[BASE + N];
    dcnt[0] = 0;
    dcnt[1] = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 22; c++) begin
      for (int d = 0; d < 2; d++) begin
        int lat;
        int dd;
        lat = (d == 0) ? 1 : 3;
        dd  = N + 2 + lat;
        s   = grab(d);
        t   = $sformatf("%s.L%0d.c%0d", name, lat, c);
        if (s.done) dcnt[d]++;
        if (c == 0) begin
          chk({t, ".busy"},  64'(s.busy),  64'd1);
          chk({t, ".valid"}, 64'(s.valid), 64'd0);
        end
        if (rst_at < 0) begin
          if (c <= dd) chk({t, ".addr"}, 64'(s.addr), 64'((c <= N) ? BASE + c : BASE + N));
          if (c == dd) begin
            chk({t, ".done"},  64'(s.done),  64'd1);
            chk({t, ".busy"},  64'(s.busy),  64'd0);
            chk({t, ".valid"}, 64'(s.valid), 64'd1);
            chk({t, ".class"}, 64'(s.cls),   64'(cls));
            chk({t, ".max"},   64'(s.mx),    64'(mx));
            chk({t, ".total"}, 64'(s.tot),   64'(tot));
          end
          if (c == dd + 1) begin
            chk({t, ".done_end"},   64'(s.done),  64'd0);
            chk({t, ".busy_next"},  64'(s.busy),  64'(hold));
            chk({t, ".valid_next"}, 64'(s.valid), 64'(!hold));
            chk({t, ".class_held"}, 64'(s.cls),   64'(cls));
            chk({t, ".max_held"},   64'(s.mx),    64'(mx));
            if (hold) chk({t, ".addr_restart"}, 64'(s.addr), 64'(BASE));
          end
        end else if (c == rst_at + 1 || c == 21) begin
          chk_zero(d, t);
        end
      end
      @(negedge clk);
      start   = hold || (c == pa) || (c == pb);
      reset_n = !(c == rst_at);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    start   = 1'b0;
    reset_n = 1'b1;
    chk({name, ".L1.done_count"}, 64'(dcnt[0]), 64'((rst_at < 0) ? 1 : 0));
    chk({name, ".L3.done_count"}, 64'(dcnt[1]), 64'((rst_at < 0) ? 1 : 0));
    if (hold) repeat (40) @(posedge clk);
  endtask

  task automatic fill_random(input bit narrow);
    int v;
    for (int k = 0; k < N; k++) begin
      if (narrow) begin
        v = int'($urandom_range(0, 6)) - 3;
        mem[BASE + k] = 32'(v);
      end else begin
        mem[BASE + k] = $urandom();
      end
    end
    mem[BASE + N] = $urandom();
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    start    = 1'b0;
    reset_n  = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_0000 | 32'(i);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_zero(0, "reset");
    chk_zero(1, "reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Reference image: expect class 1, max 0x2BD9, count 0x12345
    mem[1]  = 32'h0000_0654; mem[2]  = 32'h0000_2BD9; mem[3]  = 32'hFFFF_FAA6;
    mem[4]  = 32'hFFFF_EFBA; mem[5]  = 32'hFFFF_EDCB; mem[6]  = 32'hFFFF_F75A;
    mem[7]  = 32'hFFFF_F8F2; mem[8]  = 32'h0000_08C6; mem[9]  = 32'h0000_00F7;
    mem[10] = 32'h0000_01DA; mem[11] = 32'h0001_2345;
    run_pass("ref", -1, -1, -1, 1'b0);

    // All negative: logit k = -(k+1)
    for (int k = 0; k < N; k++) mem[BASE + k] = 32'(-(k + 1));
    mem[BASE + N] = 32'h0000_0042;
    run_pass("neg", -1, -1, -1, 1'b0);

    // Tie between logits 3 and 7
    for (int k = 0; k < N; k++) mem[BASE + k] = 32'h0;
    mem[BASE + 3] = 32'h0001_0000;
    mem[BASE + 7] = 32'h0001_0000;
    run_pass("tie", -1, -1, -1, 1'b0);

    // Start re-pulsed mid-pass is ignored
    fill_random(1'b0);
    run_pass("restart", 3, 8, -1, 1'b0);

    // Reset mid-pass, then a clean pass
    fill_random(1'b0);
    run_pass("midreset", -1, -1, 5, 1'b0);
    fill_random(1'b0);
    run_pass("after_reset", -1, -1, -1, 1'b0);

    // Start held high through DONE begins the next pass right after done
    fill_random(1'b1);
    run_pass("hold", -1, -1, -1, 1'b1);

    // Randomized passes, some with narrow values to force ties
    for (int r = 0; r < 6; r++) begin
      fill_random(r[0]);
      run_pass($sformatf("rand%0d", r), -1, -1, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
